seq_rx_checker: RTL and testbench
=================================

# seq_rx_checker

Receive-side checker for the free-running 8-bit incrementing counter stream produced by the counter generator (state counts 0, 1, 2, …, wraps 0xFF→0x00, byte emitted every clock). It sits at the consuming end of that link, locks onto the sequence, flags every out-of-sequence byte, and declares loss of lock after repeated misses. It is used in regression benches and on-chip link self-test.

## Interface
Parameters:
- LOCK_LEN, 4 — consecutive in-sequence bytes needed to declare lock (range 2..15)
- LOSS_LEN, 3 — consecutive mismatches while locked that drop lock (range 1..15)
- CNT_W, 16 — width of the saturating error counter

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous, active-high
- din  in  8  received counter byte
- din_vld  in  1  din is valid this cycle; when low the cycle is ignored entirely
- err_clr  in  1  synchronous clear of err_count
- lock  out  1  sequence locked
- err_pulse  out  1  one-cycle strobe: the previous valid byte mismatched while locked
- err_count  out  CNT_W  saturating count of mismatches seen while locked
- expected  out  8  next byte value the checker expects

## Operation
- States: HUNT, CONFIRM, LOCKED. Internal state: exp[7:0], run[3:0] (match run), miss[3:0] (consecutive misses).
- All arithmetic on exp is mod 256: 0xFF followed by 0x00 is in sequence.
- HUNT: on din_vld, exp←din+1, run←1, go CONFIRM. lock=0.
- CONFIRM: on din_vld with din==exp: exp←exp+1, run←run+1; if run+1==LOCK_LEN go LOCKED, miss←0. On din_vld with din≠exp: re-seed exp←din+1, run←1, stay in CONFIRM; no error is counted.
- LOCKED: lock=1. On din_vld with din==exp: exp←exp+1, miss←0. On din_vld with din≠exp: err_pulse asserted, err_count increments (saturates at all-ones), exp←exp+1 (the checker keeps tracking the original sequence and does not re-seed), miss←miss+1. If miss+1==LOSS_LEN, go HUNT and drop lock.
- din_vld low: no state, exp, run, miss, or counter change. err_pulse is 0.
- err_clr: err_count←0. If err_clr coincides with a counted mismatch, err_count←1. err_clr does not affect the FSM.
- expected always shows the exp register, including in HUNT, where it holds its last value.

## Timing
- Reset values: state=HUNT, lock=0, err_pulse=0, err_count=0, expected=0x00, run=0, miss=0.
- All outputs are registered. The response to the byte sampled at edge N is visible after edge N.
- Lock acquisition takes exactly LOCK_LEN valid bytes from HUNT. With the default and contiguous valid bytes, lock rises after the 4th byte's edge.
- Lock loss: lock falls on the same edge that registers the LOSS_LEN-th consecutive mismatch. That edge also produces its err_pulse.
- err_pulse is high for exactly one cycle per counted mismatch. Back-to-back mismatches give back-to-back pulses.
- Asserting rst mid-operation forces reset values immediately (asynchronous). The first valid byte after release is treated as a HUNT seed.

## Structure
- Shared package seq_chk_pkg holds the state enum typedef (HUNT, CONFIRM, LOCKED) and the byte width constant (8). The same package serves the generator side.
- Single module with no sub-modules. The saturating counter is inline logic.

## Test plan
- Reset, then feed 0x10..0x13 with din_vld=1 → lock=1 after the 4th edge, expected=0x14, err_count=0.
- Locked, feed 0xFE, 0xFF, 0x00, 0x01 → no err_pulse (wrap accepted), expected=0x02.
- Locked with expected=0x20, inject 0x55 then resume 0x21 → one err_pulse, err_count=1, lock stays 1, miss returns to 0.
- Locked, feed 3 consecutive wrong bytes → 3 err_pulses, err_count=3, lock falls on the 3rd. The next byte 0x40 reseeds: expected=0x41.
- CONFIRM with 0x05, 0x06 then 0x99 → no error counted, expected=0x9A. Lock is achieved only after 0x9A, 0x9B, 0x9C.
- Error count: preload near saturation (CNT_W=4 variant, 20 errors) → err_count holds 0xF. err_clr coincident with a mismatch → err_count=1. din_vld gaps between bytes → no state change. rst pulsed mid-lock → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/seq_chk_pkg.sv
// Shared types for the incrementing counter link.
// Used by both the generator and the receive checker.
package seq_chk_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] seq_byte_t;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } chk_state_e;

    // Successor of a sequence byte; wraps 0xFF to 0x00.
    function automatic seq_byte_t seq_next(input seq_byte_t b);
        return b + seq_byte_t'(1);
    endfunction

endpackage

// File: rtl/seq_rx_checker.sv
// Receive-side checker for the incrementing counter stream.
// Locks onto the sequence, flags and counts misses, drops lock on runs.
module seq_rx_checker
    import seq_chk_pkg::*;
#(
    parameter int LOCK_LEN = 4,
    parameter int LOSS_LEN = 3,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] din,
    input  logic              din_vld,
    input  logic              err_clr,
    output logic              lock,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  err_count,
    output logic [BYTE_W-1:0] expected
);

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_LEN);
    localparam logic [3:0] LOSS_RUN = 4'(LOSS_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    chk_state_e  state_q, state_d;
    seq_byte_t   exp_q, exp_d;
    logic [3:0]  run_q, run_d;
    logic [3:0]  miss_q, miss_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic        lock_q, lock_d;
    logic        pulse_q, pulse_d;
    logic        mism;

    // Sequence tracking: seed in HUNT, confirm a run, then track while locked.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        run_d   = run_q;
        miss_d  = miss_q;
        mism    = 1'b0;
        if (din_vld) begin
            unique case (state_q)
                HUNT: begin
                    exp_d   = seq_next(din);
                    run_d   = 4'd1;
                    state_d = CONFIRM;
                end
                CONFIRM: begin
                    if (din == exp_q) begin
                        exp_d = seq_next(exp_q);
                        run_d = run_q + 4'd1;
                        if (run_d == LOCK_RUN) begin
                            state_d = LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else begin
                        exp_d = seq_next(din);
                        run_d = 4'd1;
                    end
                end
                LOCKED: begin
                    // Keep following the original sequence even on a miss.
                    exp_d = seq_next(exp_q);
                    if (din == exp_q) begin
                        miss_d = 4'd0;
                    end else begin
                        mism   = 1'b1;
                        miss_d = miss_q + 4'd1;
                        if (miss_d == LOSS_RUN) begin
                            state_d = HUNT;
                            miss_d  = 4'd0;
                            run_d   = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // Saturating miss counter; a clear that meets a miss leaves one count.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = mism ? CNT_ONE : '0;
        end else if (mism && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
        end
    end

    // Registered status outputs derived from the next state.
    always_comb begin
        lock_d  = (state_d == LOCKED);
        pulse_d = mism;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= HUNT;
            exp_q     <= '0;
            run_q     <= 4'd0;
            miss_q    <= 4'd0;
            err_cnt_q <= '0;
            lock_q    <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            run_q     <= run_d;
            miss_q    <= miss_d;
            err_cnt_q <= err_cnt_d;
            lock_q    <= lock_d;
            pulse_q   <= pulse_d;
        end
    end

    assign lock      = lock_q;
    assign err_pulse = pulse_q;
    assign err_count = err_cnt_q;
    assign expected  = exp_q;

endmodule

// File: tb/tb_seq_rx_checker.sv
// Bench for seq_rx_checker: reference model plus directed vectors.
// Runs a default instance and a CNT_W=4 instance on the same stream.
module tb_seq_rx_checker;

    localparam int LOCK_LEN = 4;
    localparam int LOSS_LEN = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = 8'h00;
    logic        din_vld = 1'b0;
    logic        err_clr = 1'b0;

    logic        lock, err_pulse;
    logic [15:0] err_count;
    logic [7:0]  expected;
    logic        lock4, err_pulse4;
    logic [3:0]  err_count4;
    logic [7:0]  expected4;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    seq_rx_checker #(.LOCK_LEN(LOCK_LEN), .LOSS_LEN(LOSS_LEN), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .err_clr(err_clr),
        .lock(lock), .err_pulse(err_pulse), .err_count(err_count),
        .expected(expected)
    );

    seq_rx_checker #(.LOCK_LEN(LOCK_LEN), .LOSS_LEN(LOSS_LEN), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .err_clr(err_clr),
        .lock(lock4), .err_pulse(err_pulse4), .err_count(err_count4),
        .expected(expected4)
    );

    always #5 clk = ~clk;

    // Reference model: tracks the checker's observable behaviour with plain ints.
    // mode: 0 searching, 1 confirming a run, 2 locked.
    int m_mode = 0;
    int m_exp  = 0;
    int m_good = 0;
    int m_bad  = 0;
    int m_cnt  = 0;
    int m_cnt4 = 0;
    bit m_pulse = 1'b0;

    always @(posedge clk or posedge rst) begin
        bit hit;
        bit counted;
        if (rst) begin
            m_mode = 0; m_exp = 0; m_good = 0; m_bad = 0;
            m_cnt = 0; m_cnt4 = 0; m_pulse = 1'b0;
        end else begin
            counted = 1'b0;
            if (din_vld) begin
                hit = (int'(din) == m_exp);
                if (m_mode == 0) begin
                    m_exp = (int'(din) + 1) % 256;
                    m_good = 1;
                    m_mode = 1;
                end else if (m_mode == 1) begin
                    if (hit) begin
                        m_good++;
                        m_exp = (m_exp + 1) % 256;
                        if (m_good == LOCK_LEN) begin
                            m_mode = 2;
                            m_bad = 0;
                        end
                    end else begin
                        m_exp = (int'(din) + 1) % 256;
                        m_good = 1;
                    end
                end else begin
                    m_exp = (m_exp + 1) % 256;
                    if (hit) m_bad = 0;
                    else begin
                        counted = 1'b1;
                        m_bad++;
                        if (m_bad == LOSS_LEN) begin
                            m_mode = 0;
                            m_bad = 0;
                        end
                    end
                end
            end
            if (err_clr) begin
                m_cnt  = counted ? 1 : 0;
                m_cnt4 = counted ? 1 : 0;
            end else if (counted) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            m_pulse = counted;
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("lock", int'(lock), (m_mode == 2) ? 1 : 0);
            check("err_pulse", int'(err_pulse), int'(m_pulse));
            check("err_count", int'(err_count), m_cnt);
            check("expected", int'(expected), m_exp);
            check("lock4", int'(lock4), (m_mode == 2) ? 1 : 0);
            check("err_count4", int'(err_count4), m_cnt4);
            check("expected4", int'(expected4), m_exp);
        end
    end

    // Called at a negedge; byte is sampled at the next posedge, returns at next negedge.
    task automatic send(input logic [7:0] b, input logic clr = 1'b0);
        din = b;
        din_vld = 1'b1;
        err_clr = clr;
        @(negedge clk);
        din_vld = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            din = 8'($urandom_range(0, 255));
            din_vld = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] e;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_lock", int'(lock), 0);
        check("rst_exp", int'(expected), 0);
        check("rst_cnt", int'(err_count), 0);
        check("rst_pulse", int'(err_pulse), 0);

        // Acquire lock on 0x10..0x13.
        send(8'h10); send(8'h11); send(8'h12);
        check("lock_3rd", int'(lock), 0);
        send(8'h13);
        check("lock_4th", int'(lock), 1);
        check("lock_exp", int'(expected), 8'h14);
        check("lock_cnt", int'(err_count), 0);

        // Run up to the wrap and across it.
        for (int v = 8'h14; v <= 8'hFD; v++) send(8'(v));
        send(8'hFE); send(8'hFF); send(8'h00); send(8'h01);
        check("wrap_exp", int'(expected), 8'h02);
        check("wrap_cnt", int'(err_count), 0);

        // Single injected error at expected 0x20.
        for (int v = 8'h02; v <= 8'h1F; v++) send(8'(v));
        check("pre_inj_exp", int'(expected), 8'h20);
        send(8'h55);
        check("inj_pulse", int'(err_pulse), 1);
        check("inj_cnt", int'(err_count), 1);
        check("inj_lock", int'(lock), 1);
        send(8'h21);
        check("inj_resume_pulse", int'(err_pulse), 0);
        check("inj_resume_exp", int'(expected), 8'h22);

        // Clear, then three consecutive misses drop lock.
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr_cnt", int'(err_count), 0);
        send(8'hAA); send(8'hAA);
        check("miss2_lock", int'(lock), 1);
        send(8'hAA);
        check("miss3_pulse", int'(err_pulse), 1);
        check("miss3_cnt", int'(err_count), 3);
        check("miss3_lock", int'(lock), 0);
        send(8'h40);
        check("reseed_exp", int'(expected), 8'h41);

        // Confirm phase re-seeds on a mismatch without counting it.
        send(8'h05); send(8'h06); send(8'h99);
        check("conf_exp", int'(expected), 8'h9A);
        check("conf_cnt", int'(err_count), 3);
        send(8'h9A); send(8'h9B);
        check("conf_lock_early", int'(lock), 0);
        send(8'h9C);
        check("conf_lock", int'(lock), 1);

        // Gaps freeze everything.
        idle(3);
        check("gap_exp", int'(expected), 8'h9D);
        check("gap_lock", int'(lock), 1);
        send(8'h9D); idle(2); send(8'h9E); idle(1);
        check("gap_exp2", int'(expected), 8'h9F);

        // Clear coinciding with a counted miss.
        send(8'h00, 1'b1);
        check("clr_miss_cnt", int'(err_count), 1);
        check("clr_miss_pulse", int'(err_pulse), 1);
        send(8'hA0);

        // Twenty more misses interleaved with hits: saturate the 4-bit counter.
        e = 8'hA1;
        for (int i = 0; i < 20; i++) begin
            send(~e);
            send(e + 8'd1);
            e = e + 8'd2;
        end
        check("sat_cnt4", int'(err_count4), 15);
        check("sat_cnt16", int'(err_count), 21);
        check("sat_lock", int'(lock), 1);

        // Asynchronous reset mid-lock.
        din_vld = 1'b1;
        din = e;
        @(posedge clk);
        #2;
        din_vld = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_lock", int'(lock), 0);
        check("arst_exp", int'(expected), 0);
        check("arst_cnt", int'(err_count), 0);
        check("arst_pulse", int'(err_pulse), 0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h77);
        check("post_rst_exp", int'(expected), 8'h78);
        check("post_rst_lock", int'(lock), 0);

        idle(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
